mbit_sel_pipe: RTL and testbench
================================

Name: mbit_sel_pipe

Overview:
Parametrised, pipelined part-select extractor. It holds a source vector whose logical bit indices run from SRC_LSB to SRC_LSB+SRC_W-1, and serves runtime (lsb, len) field requests over a valid/ready handshake. Selected bits that fall outside the source range are replaced by a programmable fill value. Each result carries out-of-range flags, and a saturating counter tallies out-of-range results for coverage and debug.

Parameters:
SRC_W, 4, source vector width in bits
SRC_LSB, 1, logical index of source bit 0 (signed integer; may be 0 or negative)
OUT_W, 4, maximum field width and result width
IDX_W, 8, width of the signed request index
LEN_W, 3, width of the length field, clog2(OUT_W+1)
CNT_W, 16, width of the out-of-range counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
load_en  in  1  write src_in into the source register
src_in  in  SRC_W  new source value; packed bit j = logical index SRC_LSB+j
fill_mode  in  1  0 = zero-fill out-of-range bits, 1 = one-fill; sampled with the request
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_lsb  in  IDX_W  signed logical index of field bit 0
req_len  in  LEN_W  number of bits to select
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  OUT_W  extracted field, right-aligned
res_oor_any  out  1  at least one selected bit was out of range
res_oor_all  out  1  every selected bit was out of range (effective len>0)
oor_count  out  CNT_W  saturating count of delivered results with oor_any=1
cnt_clr  in  1  synchronous clear of oor_count

Behaviour:
- Reset: src_q=0, both stage valids=0, res_data=0, res_oor_any=0, res_oor_all=0, oor_count=0. Asserting reset mid-operation drops in-flight requests.
- Effective length L = min(req_len, OUT_W). If req_len=0: res_data=0 and both flags 0.
- For k in 0..L-1, idx = req_lsb + k, computed signed at IDX_W+1 bits with no wrap:
  - If SRC_LSB <= idx <= SRC_LSB+SRC_W-1, res_data[k] = src_q[idx-SRC_LSB].
  - Otherwise res_data[k] = fill_mode, and the bit counts as out of range.
- res_data[k] = 0 for k >= L.
- Stage 1 registers, at acceptance: the selected in-range bits, the per-bit in-range mask, L and fill_mode. It does not keep a live reference to src_q, so later loads do not change an accepted request.
- Stage 2 registers the assembled res_data and the flags.
- Latency: accept at edge N produces res_valid high after edge N+1 (two register stages). Throughput is one request per cycle when res_ready=1.
- Handshake and stalls:
  - Stage 2 advances when !res_valid || res_ready. Stage 1 advances when stage 2 can take it.
  - req_ready = !s1_valid || stage-2 advance.
  - res_data and the flags stay stable while res_valid && !res_ready. No request is dropped or reordered.
- Simultaneous load_en and accepted request: the request sees the pre-edge src_q (old value). src_q updates at the same edge.
- oor_count increments on res_valid && res_ready && res_oor_any and saturates at all-ones. If cnt_clr coincides with an increment, the clear wins and the count becomes 0.
- The datapath is free of X: out-of-range bits are always the fill value and never undefined.

Decomposition:
- Shared package mbit_sel_pkg holds:
  - the fill-mode constants FILL_ZERO=0 and FILL_ONE=1;
  - a function in_range(idx, lsb, w);
  - the stage-1 struct (bits, mask, len, fill).
- One natural sub-module, mbit_sel_stage. It is a generic valid/ready pipeline register, instantiated twice.
- Selection logic and the counter stay in the top module.

Test Plan:
All cases use defaults (SRC_W=4, SRC_LSB=1, OUT_W=4).
- Load src=4'h4 (logical bit 3 set); request lsb=2, len=2, fill 0 with res_ready=1 -> two cycles later res_data=4'b0010, oor_any=0, oor_all=0, oor_count stays 0.
- Load src=4'h8; request lsb=4, len=2, first fill 0, then fill 1 -> results 4'b0001 and 4'b0011, each with oor_any=1, oor_all=0; oor_count=2.
- Request lsb=-2, len=2, then lsb=5, len=4, both fill 1 -> res_data 4'b0011 and 4'b1111, oor_all=1 on both. Request with len=0 -> res_data=0, flags 0. Request with len=7 -> treated as 4: lsb=1 returns src_q.
- Hold res_ready=0 and issue 3 back-to-back requests -> two accepted, req_ready=0 on the third. The result stays stable. On release, all three arrive in order.
- Same cycle: load_en with src=4'hF and a request lsb=1, len=4 while src_q=4'h0 -> result 4'h0. The next request returns 4'hF.
- Force oor_count to all-ones via many OOR results -> the count holds at all-ones. cnt_clr together with an OOR handshake -> oor_count=0. Assert reset with both stages full -> res_valid=0 immediately and all outputs 0.

Source files
------------

// File: rtl/mbit_sel_pkg.sv
// Shared types and helpers for the mbit_sel part-select pipeline.
package mbit_sel_pkg;

    // Value driven into selected bits that fall outside the source range
    localparam logic FILL_ZERO = 1'b0;
    localparam logic FILL_ONE  = 1'b1;

    // Upper bound on the result width carried through the stage-1 record.
    // Instances must keep OUT_W <= SEL_MAX_W and OUT_W < 2**SEL_LEN_W.
    localparam int SEL_MAX_W = 32;
    localparam int SEL_LEN_W = 6;

    // Stage-1 record: the request snapshot taken at acceptance.
    // bits holds the already-fetched source bits, so later loads of the
    // source register cannot affect a request that is in flight.
    typedef struct packed {
        logic [SEL_MAX_W-1:0] bits;  // fetched source bit, valid where mask=1
        logic [SEL_MAX_W-1:0] mask;  // 1 = bit k is inside length and in range
        logic [SEL_LEN_W-1:0] len;   // effective length, already clamped
        logic                 fill;  // fill value for out-of-range bits
    } s1_t;

    // True when a signed logical index lies in [lsb, lsb+w-1]
    function automatic logic in_range(input logic signed [31:0] idx,
                                      input logic signed [31:0] lsb,
                                      input logic signed [31:0] w);
        return (idx >= lsb) && (idx <= lsb + w - 32'sd1);
    endfunction

endpackage

// File: rtl/mbit_sel_stage.sv
// Generic valid/ready pipeline register. Accepts a new word whenever the
// register is empty or its current word is being taken downstream, so a
// full chain of these sustains one transfer per cycle.
module mbit_sel_stage #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Register the incoming word; hold it (and its valid) while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/mbit_sel_pipe.sv
// Pipelined runtime part-select: extracts a (lsb, len) field from a source
// vector whose logical indices start at SRC_LSB, substituting a fill value
// for bits outside the source, flagging out-of-range results and counting
// delivered out-of-range results in a saturating counter.
module mbit_sel_pipe
    import mbit_sel_pkg::*;
#(
    parameter int SRC_W   = 4,
    parameter int SRC_LSB = 1,
    parameter int OUT_W   = 4,
    parameter int IDX_W   = 8,
    parameter int LEN_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_en,
    input  logic [SRC_W-1:0]        src_in,
    input  logic                    fill_mode,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic signed [IDX_W-1:0] req_lsb,
    input  logic [LEN_W-1:0]        req_len,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OUT_W-1:0]        res_data,
    output logic                    res_oor_any,
    output logic                    res_oor_all,
    output logic [CNT_W-1:0]        oor_count,
    input  logic                    cnt_clr
);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Logical index of field bit k; 32 bits is wide enough that the sum of
    // a sign-extended IDX_W index and k can never wrap.
    function automatic logic signed [31:0] bit_index(
        input logic signed [IDX_W-1:0] lsb,
        input int                      k
    );
        logic signed [31:0] ext;
        ext = {{(32-IDX_W){lsb[IDX_W-1]}}, lsb};
        return ext + k;
    endfunction

    // Source bit at a logical index; indices outside the source read 0,
    // so the mux never produces an undefined value.
    function automatic logic src_bit(
        input logic [SRC_W-1:0]  v,
        input logic signed [31:0] idx
    );
        logic b;
        b = 1'b0;
        for (int j = 0; j < SRC_W; j++) begin
            if (idx == SRC_LSB + j) begin
                b = v[j];
            end
        end
        return b;
    endfunction

    // Counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Source register
    // ------------------------------------------------------------------
    logic [SRC_W-1:0] src_q;

    // Load a new source; a request accepted on the same edge already
    // captured the previous contents through the stage-0 select logic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_q <= '0;
        end else if (load_en) begin
            src_q <= src_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: clamp length, fetch in-range bits, build the range mask
    // ------------------------------------------------------------------
    s1_t                sel_p0;
    logic [LEN_W-1:0]   len_eff_p0;
    logic signed [31:0] idx_p0;

    // Snapshot of everything stage 2 needs, independent of src_q afterwards
    always_comb begin
        sel_p0     = '0;
        idx_p0     = '0;
        len_eff_p0 = (req_len > LEN_W'(OUT_W)) ? LEN_W'(OUT_W) : req_len;
        sel_p0.len  = SEL_LEN_W'(len_eff_p0);
        sel_p0.fill = fill_mode ? FILL_ONE : FILL_ZERO;
        for (int k = 0; k < OUT_W; k++) begin
            idx_p0 = bit_index(req_lsb, k);
            if ((k < int'(len_eff_p0)) && in_range(idx_p0, SRC_LSB, SRC_W)) begin
                sel_p0.mask[k] = 1'b1;
                sel_p0.bits[k] = src_bit(src_q, idx_p0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    s1_t  sel_p1;
    logic vld_p1;
    logic rdy_p2;

    mbit_sel_stage #(
        .W ($bits(s1_t))
    ) u_stage1 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (req_valid),
        .in_ready  (req_ready),
        .in_data   (sel_p0),
        .out_valid (vld_p1),
        .out_ready (rdy_p2),
        .out_data  (sel_p1)
    );

    // Bits of the stage-1 record beyond OUT_W are always zero and unread
    if (OUT_W < SEL_MAX_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^{sel_p1.bits[SEL_MAX_W-1:OUT_W],
                             sel_p1.mask[SEL_MAX_W-1:OUT_W]};
    end

    // ------------------------------------------------------------------
    // Stage 1 -> 2: assemble the field and derive the range flags
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] data_p1;
    logic [OUT_W-1:0] oor_p1;
    logic             any_p1;
    logic             all_p1;

    // Masked bits come from the snapshot, the rest of the length is fill,
    // and everything beyond the length is zero.
    always_comb begin
        data_p1 = '0;
        oor_p1  = '0;
        for (int k = 0; k < OUT_W; k++) begin
            if (k < int'(sel_p1.len)) begin
                if (sel_p1.mask[k]) begin
                    data_p1[k] = sel_p1.bits[k];
                end else begin
                    data_p1[k] = sel_p1.fill;
                    oor_p1[k]  = 1'b1;
                end
            end
        end
        any_p1 = |oor_p1;
        // mask is only set inside the length, so no mask bit means every
        // selected bit was out of range
        all_p1 = (sel_p1.len != '0) && !(|sel_p1.mask[OUT_W-1:0]);
    end

    // ------------------------------------------------------------------
    // Stage 2 register (result outputs)
    // ------------------------------------------------------------------
    logic [OUT_W+1:0] res_p2;
    logic             vld_p2;

    mbit_sel_stage #(
        .W (OUT_W + 2)
    ) u_stage2 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (vld_p1),
        .in_ready  (rdy_p2),
        .in_data   ({data_p1, any_p1, all_p1}),
        .out_valid (vld_p2),
        .out_ready (res_ready),
        .out_data  (res_p2)
    );

    assign res_valid   = vld_p2;
    assign res_data    = res_p2[OUT_W+1:2];
    assign res_oor_any = res_p2[1];
    assign res_oor_all = res_p2[0];

    // ------------------------------------------------------------------
    // Out-of-range result counter
    // ------------------------------------------------------------------
    logic res_fire;
    assign res_fire = res_valid && res_ready;

    // Count delivered out-of-range results; a clear overrides an increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oor_count <= '0;
        end else if (cnt_clr) begin
            oor_count <= '0;
        end else if (res_fire && res_oor_any) begin
            oor_count <= sat_inc(oor_count);
        end
    end

endmodule

// File: tb/tb_mbit_sel_pipe.sv
// Bench for mbit_sel_pipe: a request-level reference model fills an
// expectation queue at acceptance; a monitor compares every valid result
// and the out-of-range count each cycle. Directed literals pin the model.
module tb_mbit_sel_pipe;

    localparam int SRC_W   = 4;
    localparam int SRC_LSB = 1;
    localparam int OUT_W   = 4;
    localparam int IDX_W   = 8;
    localparam int LEN_W   = 3;
    localparam int CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    load_en;
    logic [SRC_W-1:0]        src_in;
    logic                    fill_mode;
    logic                    req_valid;
    logic                    req_ready;
    logic signed [IDX_W-1:0] req_lsb;
    logic [LEN_W-1:0]        req_len;
    logic                    res_valid;
    logic                    res_ready;
    logic [OUT_W-1:0]        res_data;
    logic                    res_oor_any;
    logic                    res_oor_all;
    logic [CNT_W-1:0]        oor_count;
    logic                    cnt_clr;

    mbit_sel_pipe #(
        .SRC_W(SRC_W), .SRC_LSB(SRC_LSB), .OUT_W(OUT_W),
        .IDX_W(IDX_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .load_en(load_en), .src_in(src_in),
        .fill_mode(fill_mode), .req_valid(req_valid), .req_ready(req_ready),
        .req_lsb(req_lsb), .req_len(req_len), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_oor_any(res_oor_any),
        .res_oor_all(res_oor_all), .oor_count(oor_count), .cnt_clr(cnt_clr)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {data, oor_any, oor_all} straight from the selection rules
    function automatic logic [OUT_W+1:0] model_res(input logic [SRC_W-1:0] src,
                                                   input int lsb, input int len,
                                                   input logic fill);
        int L;
        int idx;
        int n_oor;
        logic [OUT_W-1:0] d;
        L = (len > OUT_W) ? OUT_W : len;
        d = '0;
        n_oor = 0;
        for (int k = 0; k < L; k++) begin
            idx = lsb + k;
            if (idx >= SRC_LSB && idx < SRC_LSB + SRC_W) begin
                d[k] = src[idx - SRC_LSB];
            end else begin
                d[k] = fill;
                n_oor++;
            end
        end
        return {d, (n_oor > 0), (L > 0 && n_oor == L)};
    endfunction

    // Model state: source copy, pending results, expected count
    logic [SRC_W-1:0]  m_src = '0;
    logic [OUT_W+1:0]  exp_q[$];
    logic [CNT_W-1:0]  m_count = '0;

    // Single compare process, sampling mid-cycle away from the active edge
    always @(negedge clock) begin
        logic [OUT_W+1:0] head;
        logic             fire_oor;
        if (reset) begin
            check("reset res_valid", 64'(res_valid), 64'd0);
            check("reset res_data", 64'(res_data), 64'd0);
            check("reset flags", 64'({res_oor_any, res_oor_all}), 64'd0);
            check("reset oor_count", 64'(oor_count), 64'd0);
            exp_q.delete();
            m_count = '0;
            m_src = '0;
        end else begin
            fire_oor = 1'b0;
            check("oor_count", 64'(oor_count), 64'(m_count));
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected result", 64'(res_valid), 64'd0);
                end else begin
                    head = exp_q[0];
                    check("result", 64'({res_data, res_oor_any, res_oor_all}), 64'(head));
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        fire_oor = head[1];
                    end
                end
            end
            if (cnt_clr) m_count = '0;
            else if (fire_oor && m_count != CNT_MAX) m_count = m_count + 1'b1;
            if (req_valid && req_ready)
                exp_q.push_back(model_res(m_src, int'(req_lsb), int'(req_len), fill_mode));
            if (load_en) m_src = src_in;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [SRC_W-1:0] v);
        load_en = 1'b1;
        src_in  = v;
        tick();
        load_en = 1'b0;
    endtask

    // Present a request and hold it until the handshake completes
    task automatic send(input int lsb, input int len, input logic fill);
        logic accepted;
        int   guard;
        req_valid = 1'b1;
        req_lsb   = IDX_W'(lsb);
        req_len   = LEN_W'(len);
        fill_mode = fill;
        guard     = 0;
        do begin
            accepted = req_ready;
            tick();
            guard++;
        end while (!accepted && guard < 50);
        if (!accepted) check("request accept timeout", 64'(accepted), 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        logic accepted;
        int   guard;
        reset = 1'b1; load_en = 1'b0; src_in = '0; fill_mode = 1'b0;
        req_valid = 1'b0; req_lsb = '0; req_len = '0; res_ready = 1'b1; cnt_clr = 1'b0;

        // Pin the reference model with hand-computed values
        check("model lsb2 len2", 64'(model_res(4'h4, 2, 2, 1'b0)), 64'(6'b0010_00));
        check("model partial fill0", 64'(model_res(4'h8, 4, 2, 1'b0)), 64'(6'b0001_10));
        check("model partial fill1", 64'(model_res(4'h8, 4, 2, 1'b1)), 64'(6'b0011_10));
        check("model below range", 64'(model_res(4'h8, -2, 2, 1'b1)), 64'(6'b0011_11));
        check("model above range", 64'(model_res(4'h8, 5, 4, 1'b1)), 64'(6'b1111_11));
        check("model len0", 64'(model_res(4'hF, 2, 0, 1'b1)), 64'(6'b0000_00));
        check("model len clamp", 64'(model_res(4'hA, 1, 7, 1'b0)), 64'(6'b1010_00));

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("post-reset res_valid", 64'(res_valid), 64'd0);
        check("post-reset req_ready", 64'(req_ready), 64'd1);

        // Basic in-range extraction
        do_load(4'h4);
        send(2, 2, 1'b0);
        drain();
        check("count after in-range", 64'(oor_count), 64'd0);

        // Partial out of range, zero and one fill
        do_load(4'h8);
        send(4, 2, 1'b0);
        send(4, 2, 1'b1);
        drain();
        check("count after partial", 64'(oor_count), 64'd2);

        // Fully out of range both sides, zero length, clamped length
        send(-2, 2, 1'b1);
        send(5, 4, 1'b1);
        send(3, 0, 1'b1);
        do_load(4'hA);
        send(1, 7, 1'b0);
        drain();
        check("count after full oor", 64'(oor_count), 64'd4);

        // Backpressure: two requests fill the pipe, the third waits
        res_ready = 1'b0;
        send(1, 1, 1'b0);
        send(2, 1, 1'b0);
        check("stall req_ready", 64'(req_ready), 64'd0);
        check("stall res_valid", 64'(res_valid), 64'd1);
        req_valid = 1'b1; req_lsb = 8'sd3; req_len = 3'd1; fill_mode = 1'b0;
        repeat (3) tick();
        check("stall req_ready held", 64'(req_ready), 64'd0);
        res_ready = 1'b1;
        guard = 0;
        do begin
            accepted = req_ready;
            tick();
            guard++;
        end while (!accepted && guard < 50);
        check("third request accepted", 64'(accepted), 64'd1);
        req_valid = 1'b0;
        drain();

        // Load and request on the same edge: the request sees the old source
        do_load(4'h0);
        check("same-edge req_ready", 64'(req_ready), 64'd1);
        load_en = 1'b1; src_in = 4'hF;
        req_valid = 1'b1; req_lsb = 8'sd1; req_len = 3'd4; fill_mode = 1'b0;
        tick();
        load_en = 1'b0; req_valid = 1'b0;
        send(1, 4, 1'b0);
        drain();

        // Stream out-of-range results until the counter saturates
        req_valid = 1'b1; req_lsb = 8'sd10; req_len = 3'd1; fill_mode = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 65545; i++) tick();
        check("count saturated", 64'(oor_count), 64'(CNT_MAX));
        tick();
        check("count holds at max", 64'(oor_count), 64'(CNT_MAX));
        // Clear coinciding with an out-of-range handshake
        check("clear cycle res_valid", 64'(res_valid), 64'd1);
        req_valid = 1'b0;
        cnt_clr   = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clear beats increment", 64'(oor_count), 64'd0);
        drain();
        check("no lost results", 64'(exp_q.size()), 64'd0);

        // Reset with both stages full
        res_ready = 1'b0;
        send(1, 4, 1'b0);
        send(2, 2, 1'b1);
        check("full before reset", 64'(res_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("async reset res_valid", 64'(res_valid), 64'd0);
        check("async reset res_data", 64'(res_data), 64'd0);
        check("async reset flags", 64'({res_oor_any, res_oor_all}), 64'd0);
        check("async reset count", 64'(oor_count), 64'd0);
        tick();
        reset = 1'b0;
        res_ready = 1'b1;
        tick();
        tick();
        check("after reset no result", 64'(res_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
